sgdma_desc_fetch: RTL and testbench
===================================

Name: sgdma_desc_fetch

Overview:
Descriptor-fetch engine for the simple scatter-gather DMA. It sits directly downstream of the AXI4-Lite control register slave. On a start pulse it walks a linked list of 16-byte descriptors in DDR using an AXI4 read master. It emits each descriptor as a valid/ready command to the data mover and reports done/error status back to the register file.

Parameters:
ADDR_W, 32, AXI address width and width of descriptor pointers.
MAX_DESC, 1024, descriptor-count limit per run; exceeding it is a loop error.

Ports:
ACLK  in  1  clock
ARESETN  in  1  reset, asynchronous, active-low
start  in  1  single-cycle pulse from the register file
head_ptr  in  ADDR_W  first descriptor address; bits [3:0] are ignored and forced to 0
busy  out  1  high from the accepted start until the done or err pulse
done  out  1  one-cycle pulse on normal list completion
err  out  1  one-cycle pulse on abnormal termination
err_code  out  2  0=none, 1=bus RRESP error, 2=MAX_DESC exceeded; held until next accepted start
desc_count  out  16  descriptors emitted in the current or last run
m_axi_araddr  out  ADDR_W  descriptor address
m_axi_arlen  out  8  constant 3
m_axi_arsize  out  3  constant 2
m_axi_arburst  out  2  constant 1 (INCR)
m_axi_arvalid  out  1  AR valid
m_axi_arready  in  1  AR ready
m_axi_rdata  in  32  R data
m_axi_rresp  in  2  R response
m_axi_rlast  in  1  R last
m_axi_rvalid  in  1  R valid
m_axi_rready  out  1  R ready
desc_addr  out  ADDR_W  buffer address to the data mover
desc_len  out  24  buffer length in bytes
desc_last  out  1  final descriptor of the list
desc_valid  out  1  descriptor valid
desc_ready  in  1  data mover ready

Behaviour:
- Reset values: all outputs 0, except the ar* constant outputs; state is IDLE.
- Descriptor layout, in beat order:
  - w0: next_ptr.
  - w1: buf_addr.
  - w2: [23:0] len, [31] last flag.
  - w3: reserved, discarded.
- IDLE: start latches head_ptr&~0xF into cur_ptr, clears desc_count and err_code, sets busy, and goes to AR. A start while busy is ignored.
- AR:
  - arvalid=1 with araddr=cur_ptr.
  - araddr and arvalid are stable until arready.
  - On handshake, go to R.
  - Exactly one outstanding burst at a time.
- R:
  - rready=1 while in R.
  - A 2-bit beat counter captures w0..w2 and discards w3.
  - Any rresp!=0 sets a sticky bus_err flag; the remaining beats are still accepted.
  - On the rlast beat, bus_err set goes to ERR (code 1); otherwise go to CHK.
  - rlast is trusted; the beat counter is not used to end the burst.
- CHK (1 cycle):
  - len==0: the descriptor is not emitted and not counted. If it is terminal, go to DONE; otherwise go to NEXT.
  - Otherwise go to EMIT.
  - Terminal means last flag=1 or next_ptr==0.
- EMIT:
  - desc_valid=1 with the fields registered.
  - desc_last = terminal.
  - Fields are stable until desc_ready.
  - On handshake, desc_count increments; then go to DONE if terminal, else NEXT.
- NEXT:
  - If desc_count==MAX_DESC, go to ERR (code 2).
  - Otherwise cur_ptr=next_ptr&~0xF and go to AR.
- DONE: done=1 for 1 cycle, busy=0, then IDLE.
- ERR: err=1 for 1 cycle, busy=0, err_code held, then IDLE.
- Latency: minimum start→arvalid is 1 cycle. Last rlast→desc_valid is 2 cycles (R→CHK→EMIT).
- desc_count saturates at 0xFFFF. MAX_DESC is checked before it can wrap.
- Async reset mid-burst abandons the transaction; the interconnect is reset on the same ARESETN.

Decomposition:
- Package sgdma_pkg:
  - Descriptor word offsets and LAST bit index (31).
  - Struct sgdma_desc_t {addr, len, last}.
  - Enum fetch_state_t.
  - err_code constants.
  - AXI constants: ARLEN_DESC=3, ARSIZE_32=2, BURST_INCR=1.
- No sub-module is needed. The state machine and capture registers form a single module.

Test Plan:
- Three-descriptor chain at 0x1000→0x1010→0x1020:
  - Descriptors: (0x8000,0x100), (0x9000,0x40), and (0xA000,0x10) with last=1.
  - Required: three descriptors emitted in order; desc_last only on the third; done pulse; desc_count=3; err_code=0.
- Back-pressure and ready delays:
  - Stimulus: desc_ready low for 5 cycles; arready delayed 3 cycles.
  - Required: desc_*, araddr and arvalid stable throughout; no extra AR issued.
- Bus error: rresp=2 (SLVERR) on beat 1 of the second descriptor.
  - Required: all 4 beats accepted and rready held; no second descriptor emitted; err pulse; err_code=1; desc_count=1.
- Zero-length descriptor in the middle (len=0, next≠0), and head_ptr=0x1004.
  - Required: the zero-length descriptor is skipped; araddr=0x1000; desc_count excludes it.
- Loop error: MAX_DESC=4 with a self-pointing descriptor (next=own address, last=0).
  - Required: 4 emitted, then err with err_code=2.
- Control edge cases:
  - Start pulsed while busy: ignored.
  - ARESETN deasserted mid-R: all outputs 0 asynchronously.
  - A new start after reset runs normally.

Source files
------------

// File: rtl/sgdma_desc_fetch_pkg.sv
// Shared types and constants for the scatter-gather DMA descriptor fetch engine.
// Descriptors are four 32-bit words: next_ptr, buf_addr, {last, len}, reserved.
package sgdma_pkg;

  localparam logic [1:0] W_NEXT = 2'd0;
  localparam logic [1:0] W_BUF  = 2'd1;
  localparam logic [1:0] W_LEN  = 2'd2;
  localparam logic [1:0] W_RSVD = 2'd3;
  localparam int         LAST_BIT = 31;
  localparam int         LEN_W    = 24;

  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_BUS  = 2'd1;
  localparam logic [1:0] ERR_LOOP = 2'd2;

  localparam logic [7:0] ARLEN_DESC = 8'd3;
  localparam logic [2:0] ARSIZE_32  = 3'd2;
  localparam logic [1:0] BURST_INCR = 2'd1;

  typedef struct packed {
    logic [31:0]      addr;
    logic [LEN_W-1:0] len;
    logic             last;
  } sgdma_desc_t;

  typedef enum logic [2:0] {
    ST_IDLE, ST_AR, ST_R, ST_CHK, ST_EMIT, ST_NEXT, ST_DONE, ST_ERR
  } fetch_state_t;

  // A descriptor ends the list when its last flag is set or it links to null.
  function automatic logic is_terminal(input logic [31:0] next_ptr, input logic last_flag);
    return last_flag || (next_ptr == 32'd0);
  endfunction

endpackage

// File: rtl/sgdma_desc_fetch_if.sv
// AXI4 read-master channels plus the descriptor command stream of the fetch engine.
// The master modport is the fetch engine's view; slave is memory / data mover.
interface sgdma_desc_fetch_if #(parameter int ADDR_W = 32);

  logic [ADDR_W-1:0] m_axi_araddr;
  logic [7:0]        m_axi_arlen;
  logic [2:0]        m_axi_arsize;
  logic [1:0]        m_axi_arburst;
  logic              m_axi_arvalid;
  logic              m_axi_arready;
  logic [31:0]       m_axi_rdata;
  logic [1:0]        m_axi_rresp;
  logic              m_axi_rlast;
  logic              m_axi_rvalid;
  logic              m_axi_rready;
  logic [ADDR_W-1:0] desc_addr;
  logic [23:0]       desc_len;
  logic              desc_last;
  logic              desc_valid;
  logic              desc_ready;

  modport master (
    output m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arvalid,
    input  m_axi_arready,
    input  m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid,
    output m_axi_rready,
    output desc_addr, desc_len, desc_last, desc_valid,
    input  desc_ready
  );

  modport slave (
    input  m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arvalid,
    output m_axi_arready,
    output m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid,
    input  m_axi_rready,
    input  desc_addr, desc_len, desc_last, desc_valid,
    output desc_ready
  );

endinterface

// File: rtl/sgdma_desc_fetch.sv
// Walks a linked list of 16-byte descriptors with single 4-beat AXI bursts and
// hands each non-empty descriptor to the data mover over valid/ready.
module sgdma_desc_fetch
  import sgdma_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int MAX_DESC = 1024
) (
  input  logic              ACLK,
  input  logic              ARESETN,
  input  logic              start,
  input  logic [ADDR_W-1:0] head_ptr,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [1:0]        err_code,
  output logic [15:0]       desc_count,
  sgdma_desc_fetch_if.master bus
);

  localparam logic [15:0] MAX_DESC_16 = 16'(MAX_DESC);

  fetch_state_t      state_reg, state_next;
  logic [ADDR_W-1:0] cur_ptr_reg;
  logic [31:0]       next_ptr_reg;
  logic [31:0]       buf_addr_reg;
  logic [LEN_W-1:0]  len_reg;
  logic              last_flag_reg;
  logic [1:0]        beat_reg;
  logic              bus_err_reg;
  sgdma_desc_t       desc_reg;
  logic [1:0]        err_code_reg;
  logic [15:0]       desc_count_reg;

  logic ar_valid, r_ready, d_valid, busy_c, done_c, err_c;
  logic terminal, beat_err;

  function automatic logic [ADDR_W-1:0] align16(input logic [ADDR_W-1:0] p);
    return p & ~ADDR_W'(15);
  endfunction

  assign terminal = is_terminal(next_ptr_reg, last_flag_reg);
  // The error decision on the rlast beat must include that beat's own response.
  assign beat_err = bus_err_reg || (bus.m_axi_rresp != 2'b00);

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) state_reg <= ST_IDLE;
    else          state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    ar_valid   = 1'b0;
    r_ready    = 1'b0;
    d_valid    = 1'b0;
    busy_c     = 1'b1;
    done_c     = 1'b0;
    err_c      = 1'b0;
    unique case (state_reg)
      ST_IDLE: begin
        busy_c = 1'b0;
        if (start) state_next = ST_AR;
      end
      ST_AR: begin
        ar_valid = 1'b1;
        if (bus.m_axi_arready) state_next = ST_R;
      end
      ST_R: begin
        r_ready = 1'b1;
        if (bus.m_axi_rvalid && bus.m_axi_rlast) state_next = beat_err ? ST_ERR : ST_CHK;
      end
      ST_CHK: begin
        if (len_reg == '0) state_next = terminal ? ST_DONE : ST_NEXT;
        else               state_next = ST_EMIT;
      end
      ST_EMIT: begin
        d_valid = 1'b1;
        if (bus.desc_ready) state_next = desc_reg.last ? ST_DONE : ST_NEXT;
      end
      ST_NEXT: state_next = (desc_count_reg == MAX_DESC_16) ? ST_ERR : ST_AR;
      ST_DONE: begin
        busy_c     = 1'b0;
        done_c     = 1'b1;
        state_next = ST_IDLE;
      end
      ST_ERR: begin
        busy_c     = 1'b0;
        err_c      = 1'b1;
        state_next = ST_IDLE;
      end
      default: begin
        busy_c     = 1'b0;
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      cur_ptr_reg    <= '0;
      next_ptr_reg   <= '0;
      buf_addr_reg   <= '0;
      len_reg        <= '0;
      last_flag_reg  <= 1'b0;
      beat_reg       <= '0;
      bus_err_reg    <= 1'b0;
      desc_reg       <= '0;
      err_code_reg   <= ERR_NONE;
      desc_count_reg <= '0;
    end else begin
      unique case (state_reg)
        ST_IDLE: if (start) begin
          cur_ptr_reg    <= align16(head_ptr);
          desc_count_reg <= '0;
          err_code_reg   <= ERR_NONE;
        end
        ST_AR: if (bus.m_axi_arready) begin
          beat_reg    <= '0;
          bus_err_reg <= 1'b0;
        end
        ST_R: if (bus.m_axi_rvalid) begin
          beat_reg <= beat_reg + 2'd1;
          if (bus.m_axi_rresp != 2'b00) bus_err_reg <= 1'b1;
          if (bus.m_axi_rlast && beat_err) err_code_reg <= ERR_BUS;
          unique case (beat_reg)
            W_NEXT: next_ptr_reg <= bus.m_axi_rdata;
            W_BUF:  buf_addr_reg <= bus.m_axi_rdata;
            W_LEN: begin
              len_reg       <= bus.m_axi_rdata[LEN_W-1:0];
              last_flag_reg <= bus.m_axi_rdata[LAST_BIT];
            end
            W_RSVD: ;
            default: ;
          endcase
        end
        ST_CHK: desc_reg <= '{addr: buf_addr_reg, len: len_reg, last: terminal};
        ST_EMIT: if (bus.desc_ready && desc_count_reg != 16'hFFFF)
          desc_count_reg <= desc_count_reg + 16'd1;
        ST_NEXT: begin
          if (desc_count_reg == MAX_DESC_16) err_code_reg <= ERR_LOOP;
          else                               cur_ptr_reg  <= align16(ADDR_W'(next_ptr_reg));
        end
        default: ;
      endcase
    end
  end

  assign busy       = busy_c;
  assign done       = done_c;
  assign err        = err_c;
  assign err_code   = err_code_reg;
  assign desc_count = desc_count_reg;

  assign bus.m_axi_araddr  = cur_ptr_reg;
  assign bus.m_axi_arlen   = ARLEN_DESC;
  assign bus.m_axi_arsize  = ARSIZE_32;
  assign bus.m_axi_arburst = BURST_INCR;
  assign bus.m_axi_arvalid = ar_valid;
  assign bus.m_axi_rready  = r_ready;
  assign bus.desc_addr     = ADDR_W'(desc_reg.addr);
  assign bus.desc_len      = desc_reg.len;
  assign bus.desc_last     = desc_reg.last;
  assign bus.desc_valid    = d_valid;

endmodule

// File: tb/tb_sgdma_desc_fetch.sv
// Scoreboard bench: a list-walking reference model predicts AR addresses,
// emitted descriptors and the run outcome; a negedge monitor compares them.
module tb_sgdma_desc_fetch;
  import sgdma_pkg::*;

  localparam int MAXD = 4;

  logic        ACLK = 1'b0;
  logic        ARESETN = 1'b0;
  logic        start = 1'b0;
  logic [31:0] head_ptr = '0;
  logic        busy, done, err;
  logic [1:0]  err_code;
  logic [15:0] desc_count;

  sgdma_desc_fetch_if #(.ADDR_W(32)) bus_if();

  sgdma_desc_fetch #(.ADDR_W(32), .MAX_DESC(MAXD)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN), .start(start), .head_ptr(head_ptr),
    .busy(busy), .done(done), .err(err), .err_code(err_code),
    .desc_count(desc_count), .bus(bus_if)
  );

  always #5 ACLK = ~ACLK;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct { bit [31:0] addr; bit [23:0] len; bit last; } exp_desc_t;
  typedef struct { bit is_err; bit [1:0] code; int count; } exp_out_t;

  bit [31:0] exp_ar_q[$];
  exp_desc_t exp_desc_q[$];
  exp_out_t  exp_out_q[$];

  bit [31:0] mem [bit [31:0]];
  bit        err_at [bit [31:0]];

  function automatic bit [31:0] rd(input bit [31:0] a);
    if (mem.exists(a)) return mem[a];
    return 32'd0;
  endfunction

  task automatic put_desc(input bit [31:0] a, input bit [31:0] nxt, input bit [31:0] b,
                          input bit [23:0] len, input bit last);
    mem[a]      = nxt;
    mem[a + 4]  = b;
    mem[a + 8]  = {last, 7'd0, len};
    mem[a + 12] = $urandom;
  endtask

  // Reference: follow the list in memory and record what a correct engine would do.
  function automatic void model_run(input bit [31:0] head);
    bit [31:0] p, nxt, b, w2;
    bit        term;
    int        cnt;
    exp_desc_t d;
    exp_out_t  o;
    p = head & 32'hFFFF_FFF0;
    cnt = 0;
    for (int i = 0; i < 64; i++) begin
      exp_ar_q.push_back(p);
      if (err_at.exists(p)) begin
        o.is_err = 1'b1; o.code = 2'd1; o.count = cnt;
        exp_out_q.push_back(o);
        return;
      end
      nxt = rd(p); b = rd(p + 4); w2 = rd(p + 8);
      term = w2[31] || (nxt == 32'd0);
      if (w2[23:0] != 24'd0) begin
        d.addr = b; d.len = w2[23:0]; d.last = term;
        exp_desc_q.push_back(d);
        cnt++;
      end
      if (term) begin
        o.is_err = 1'b0; o.code = 2'd0; o.count = cnt;
        exp_out_q.push_back(o);
        return;
      end
      if (cnt == MAXD) begin
        o.is_err = 1'b1; o.code = 2'd2; o.count = cnt;
        exp_out_q.push_back(o);
        return;
      end
      p = nxt & 32'hFFFF_FFF0;
    end
  endfunction

  // ---------------- memory slave / data-mover driver ----------------
  int        ar_delay = -1;
  int        dr_hold  = -1;
  bit        rd_active;
  bit [31:0] rd_addr;
  int        rd_beat, ar_cnt, dr_cnt;
  bit        p_arvalid, p_rready, p_dvalid;
  bit [31:0] p_araddr;

  initial begin
    bus_if.m_axi_arready = 1'b0;
    bus_if.m_axi_rvalid  = 1'b0;
    bus_if.m_axi_rdata   = '0;
    bus_if.m_axi_rresp   = '0;
    bus_if.m_axi_rlast   = 1'b0;
    bus_if.desc_ready    = 1'b0;
    forever begin
      @(posedge ACLK);
      #2;
      if (!ARESETN) begin
        rd_active = 0; ar_cnt = 0; dr_cnt = 0;
        p_arvalid = 0; p_rready = 0; p_dvalid = 0;
        bus_if.m_axi_arready = 1'b0;
        bus_if.m_axi_rvalid  = 1'b0;
        bus_if.m_axi_rlast   = 1'b0;
        bus_if.desc_ready    = 1'b0;
      end else begin
        // retire handshakes that completed on the edge just passed
        if (bus_if.m_axi_rvalid && p_rready) begin
          if (bus_if.m_axi_rlast) rd_active = 0;
          else rd_beat++;
          bus_if.m_axi_rvalid = 1'b0;
        end
        if (p_arvalid && bus_if.m_axi_arready) begin
          chk("one_burst_outstanding", rd_active, 0);
          rd_active = 1; rd_addr = p_araddr; rd_beat = 0; ar_cnt = 0;
        end
        if (p_dvalid && bus_if.desc_ready) dr_cnt = 0;

        if (bus_if.m_axi_arvalid) begin
          if (ar_delay >= 0) bus_if.m_axi_arready = (ar_cnt >= ar_delay);
          else bus_if.m_axi_arready = ($urandom_range(0, 2) != 0);
          if (!bus_if.m_axi_arready) ar_cnt++;
        end else begin
          bus_if.m_axi_arready = 1'b0;
        end

        if (rd_active && !bus_if.m_axi_rvalid && $urandom_range(0, 3) != 0) begin
          bus_if.m_axi_rdata  = rd(rd_addr + 32'(4 * rd_beat));
          bus_if.m_axi_rresp  = (err_at.exists(rd_addr) && rd_beat == 1) ? 2'd2 : 2'd0;
          bus_if.m_axi_rlast  = (rd_beat == 3);
          bus_if.m_axi_rvalid = 1'b1;
        end
        if (rd_active) chk("rready_held", bus_if.m_axi_rready, 1);

        if (dr_hold >= 0) begin
          if (bus_if.desc_valid) begin
            bus_if.desc_ready = (dr_cnt >= dr_hold);
            if (!bus_if.desc_ready) dr_cnt++;
          end else begin
            bus_if.desc_ready = 1'b0;
          end
        end else begin
          bus_if.desc_ready = ($urandom_range(0, 9) < 7);
        end

        p_arvalid = bus_if.m_axi_arvalid;
        p_araddr  = bus_if.m_axi_araddr;
        p_rready  = bus_if.m_axi_rready;
        p_dvalid  = bus_if.desc_valid;
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  bit        m_ar_wait, m_d_wait;
  bit [31:0] m_araddr, m_daddr;
  bit [23:0] m_dlen;
  bit        m_dlast;

  always @(negedge ACLK) begin
    if (!ARESETN) begin
      m_ar_wait = 0;
      m_d_wait  = 0;
    end else begin
      if (m_ar_wait) begin
        chk("arvalid_stable", bus_if.m_axi_arvalid, 1);
        chk("araddr_stable", bus_if.m_axi_araddr, m_araddr);
      end
      if (m_d_wait) begin
        chk("desc_valid_stable", bus_if.desc_valid, 1);
        chk("desc_addr_stable", bus_if.desc_addr, m_daddr);
        chk("desc_len_stable", bus_if.desc_len, m_dlen);
        chk("desc_last_stable", bus_if.desc_last, m_dlast);
      end
      m_ar_wait = bus_if.m_axi_arvalid && !bus_if.m_axi_arready;
      m_araddr  = bus_if.m_axi_araddr;
      m_d_wait  = bus_if.desc_valid && !bus_if.desc_ready;
      m_daddr   = bus_if.desc_addr;
      m_dlen    = bus_if.desc_len;
      m_dlast   = bus_if.desc_last;

      if (bus_if.m_axi_arvalid && bus_if.m_axi_arready) begin
        chk("ar_expected", exp_ar_q.size() != 0, 1);
        if (exp_ar_q.size() != 0) chk("araddr", bus_if.m_axi_araddr, exp_ar_q.pop_front());
      end
      if (bus_if.desc_valid && bus_if.desc_ready) begin
        chk("desc_expected", exp_desc_q.size() != 0, 1);
        if (exp_desc_q.size() != 0) begin
          exp_desc_t d;
          d = exp_desc_q.pop_front();
          chk("desc_addr", bus_if.desc_addr, d.addr);
          chk("desc_len", bus_if.desc_len, d.len);
          chk("desc_last", bus_if.desc_last, d.last);
        end
      end
      if (done || err) begin
        chk("outcome_expected", exp_out_q.size() != 0, 1);
        if (exp_out_q.size() != 0) begin
          exp_out_t o;
          o = exp_out_q.pop_front();
          chk("err_pulse", err, o.is_err);
          chk("done_pulse", done, !o.is_err);
          chk("err_code", err_code, o.code);
          chk("desc_count", desc_count, o.count);
          chk("busy_low_at_end", busy, 0);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic flush_queues();
    exp_ar_q.delete();
    exp_desc_q.delete();
    exp_out_q.delete();
  endtask

  task automatic do_start(input bit [31:0] head);
    @(negedge ACLK);
    start = 1'b1;
    head_ptr = head;
    model_run(head);
    @(negedge ACLK);
    start = 1'b0;
    head_ptr = $urandom;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while ((exp_out_q.size() != 0 || busy === 1'b1) && t < 3000) begin
      @(negedge ACLK);
      t++;
    end
    chk("run_completes", t < 3000, 1);
    chk("all_ar_seen", exp_ar_q.size(), 0);
    chk("all_desc_seen", exp_desc_q.size(), 0);
    flush_queues();
    repeat (2) @(negedge ACLK);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_err_code"}, err_code, 0);
    chk({tag, "_desc_count"}, desc_count, 0);
    chk({tag, "_arvalid"}, bus_if.m_axi_arvalid, 0);
    chk({tag, "_araddr"}, bus_if.m_axi_araddr, 0);
    chk({tag, "_rready"}, bus_if.m_axi_rready, 0);
    chk({tag, "_desc_valid"}, bus_if.desc_valid, 0);
    chk({tag, "_desc_addr"}, bus_if.desc_addr, 0);
    chk({tag, "_desc_len"}, bus_if.desc_len, 0);
    chk({tag, "_desc_last"}, bus_if.desc_last, 0);
    chk({tag, "_arlen"}, bus_if.m_axi_arlen, 3);
    chk({tag, "_arsize"}, bus_if.m_axi_arsize, 2);
    chk({tag, "_arburst"}, bus_if.m_axi_arburst, 1);
  endtask

  initial begin
    repeat (3) @(negedge ACLK);
    check_all_zero("reset");
    ARESETN = 1'b1;
    @(negedge ACLK);

    // three-descriptor chain
    put_desc(32'h1000, 32'h1010, 32'h8000, 24'h100, 1'b0);
    put_desc(32'h1010, 32'h1020, 32'h9000, 24'h040, 1'b0);
    put_desc(32'h1020, 32'h5555_0000, 32'hA000, 24'h010, 1'b1);
    do_start(32'h1000);
    wait_idle();
    chk("chain_count", desc_count, 3);
    chk("chain_err_code", err_code, 0);

    // back-pressure and slow AR
    ar_delay = 3;
    dr_hold  = 5;
    do_start(32'h1000);
    wait_idle();
    ar_delay = -1;
    dr_hold  = -1;

    // SLVERR on beat 1 of the second descriptor
    put_desc(32'h2000, 32'h2010, 32'hC000, 24'h080, 1'b0);
    put_desc(32'h2010, 32'h2020, 32'hC100, 24'h080, 1'b0);
    put_desc(32'h2020, 32'h0000, 32'hC200, 24'h080, 1'b0);
    err_at[32'h2010] = 1'b1;
    do_start(32'h2000);
    wait_idle();
    chk("buserr_code", err_code, 1);
    chk("buserr_count", desc_count, 1);
    err_at.delete();

    // zero-length descriptor in the middle, unaligned head and next pointers
    put_desc(32'h1000, 32'h1013, 32'h8000, 24'h100, 1'b0);
    put_desc(32'h1010, 32'h1020, 32'h8800, 24'h000, 1'b0);
    put_desc(32'h1020, 32'h0000, 32'hA000, 24'h010, 1'b0);
    do_start(32'h1004);
    wait_idle();
    chk("zlen_count", desc_count, 2);

    // self-pointing descriptor trips the descriptor limit
    put_desc(32'h4000, 32'h4000, 32'hB000, 24'h020, 1'b0);
    do_start(32'h4000);
    wait_idle();
    chk("loop_code", err_code, 2);
    chk("loop_count", desc_count, MAXD);

    // start while busy is ignored
    do_start(32'h2000);
    repeat (2) @(negedge ACLK);
    chk("busy_during_run", busy, 1);
    start = 1'b1;
    head_ptr = 32'h4000;
    @(negedge ACLK);
    start = 1'b0;
    wait_idle();
    chk("ignored_start_count", desc_count, 3);

    // randomized chains
    for (int r = 0; r < 10; r++) begin
      bit [31:0] base, a, nxt;
      bit [23:0] ln;
      bit        lst;
      int        n;
      base = 32'h0001_0000 + 32'(r) * 32'h1000;
      n = $urandom_range(1, 6);
      for (int k = 0; k < n; k++) begin
        a  = base + 32'(k) * 32'h10;
        ln = ($urandom_range(0, 3) == 0) ? 24'd0 : 24'($urandom_range(1, 4096));
        if (k == n - 1) begin
          if ($urandom_range(0, 1) == 1) begin nxt = 32'd0; lst = 1'b0; end
          else begin nxt = 32'h00DE_AD00; lst = 1'b1; end
        end else begin
          nxt = (a + 32'h10) | 32'($urandom_range(0, 15));
          lst = 1'b0;
        end
        put_desc(a, nxt, $urandom, ln, lst);
      end
      if ($urandom_range(0, 3) == 0) err_at[base + 32'h10 * 32'($urandom_range(0, n - 1))] = 1'b1;
      do_start(base | 32'($urandom_range(0, 15)));
      wait_idle();
      err_at.delete();
    end

    // asynchronous reset in the middle of a read burst, then a clean run
    begin
      int t;
      do_start(32'h2000);
      t = 0;
      while (bus_if.m_axi_rready !== 1'b1 && t < 200) begin
        @(negedge ACLK);
        t++;
      end
      chk("reached_r_phase", bus_if.m_axi_rready, 1);
      #2;
      ARESETN = 1'b0;
      #1;
      check_all_zero("async_reset");
      flush_queues();
      repeat (2) @(negedge ACLK);
      ARESETN = 1'b1;
      @(negedge ACLK);
      do_start(32'h1000);
      wait_idle();
      chk("post_reset_count", desc_count, 2);
      chk("post_reset_err_code", err_code, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2_000_000;
    miscompares++;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
